// File: rtl/branch_sequencer_if.sv
// Decode-side branch request channel plus the ALU flag / counter register exchange.
// Also carries the shared condition-code and flag-bit encodings.
`ifndef BRANCH_SEQ_DEFINES
`define BRANCH_SEQ_DEFINES
`define ALUF_CF 0
`define ALUF_ZF 1
`define ALUF_SF 2
`define ALUF_OF 3
`define JMP_FORCE 4'h0
`define JMP_E     4'h1
`define JMP_NE    4'h2
`define JMP_A     4'h3
`define JMP_AE    4'h4
`define JMP_B     4'h5
`define JMP_BE    4'h6
`define JMP_G     4'h7
`define JMP_GE    4'h8
`define JMP_L     4'h9
`define JMP_LE    4'hA
`define JMP_S     4'hB
`define JMP_NS    4'hC
`define JMP_O     4'hD
`define JMP_NO    4'hE
`define JMP_CRZ   4'hF
`endif

interface branch_sequencer_if;
    logic        br_valid;
    logic        br_ready;
    logic [1:0]  br_op;
    logic [3:0]  br_type;
    logic [15:0] br_target;
    logic [15:0] flag;
    logic [15:0] cr_i;
    logic [15:0] cr_o;
    logic        cr_we;

    modport master (
        output br_valid, br_op, br_type, br_target, flag, cr_i,
        input  br_ready, cr_o, cr_we
    );

    modport slave (
        input  br_valid, br_op, br_type, br_target, flag, cr_i,
        output br_ready, cr_o, cr_we
    );
endinterface

// File: rtl/branch_sequencer.sv
// Program counter owner: sequential advance, conditional JMP, CALL/RET via return stack, LOOP.
// Branch latency 3 cycles (accept -> EVAL -> COMMIT); faults park the FSM in HALT until reset.
module branch_sequencer #(
    parameter int          STACK_DEPTH = 8,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_advance,
    branch_sequencer_if.slave br_if,
    output logic [15:0]       o_pc,
    output logic              o_flush,
    output logic              o_fault
);
    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [1:0] OP_JMP  = 2'd0;
    localparam logic [1:0] OP_CALL = 2'd1;
    localparam logic [1:0] OP_RET  = 2'd2;
    localparam logic [1:0] OP_LOOP = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_COMMIT, S_HALT} state_t;

    state_t         r_state, w_next;
    logic [15:0]    r_pc, r_target, r_cr;
    logic [1:0]     r_op;
    logic [3:0]     r_type;
    logic           r_zf, r_cf, r_sf, r_of;
    logic [SPW-1:0] r_sp;
    logic [15:0]    r_stack [STACK_DEPTH];
    logic           r_con, r_fault;

    logic           w_accept, w_cond, w_type_ok, w_con, w_eval_fault, w_cr_we;
    logic [15:0]    w_cr_dec, w_pc_inc;
    logic [SPW-1:0] w_sp_dec, w_sp_inc;

    assign w_accept = br_if.br_valid && (r_state == S_IDLE) && !r_fault;
    assign w_cr_dec = r_cr - 16'd1;
    assign w_pc_inc = r_pc + 16'd1;
    assign w_sp_dec = r_sp - SPW'(1);
    assign w_sp_inc = r_sp + SPW'(1);

    always_comb begin
        w_cond    = 1'b0;
        w_type_ok = 1'b1;
        case (r_type)
            `JMP_FORCE: w_cond = 1'b1;
            `JMP_E:     w_cond = r_zf;
            `JMP_NE:    w_cond = !r_zf;
            `JMP_A:     w_cond = !r_cf && !r_zf;
            `JMP_AE:    w_cond = !r_cf;
            `JMP_B:     w_cond = r_cf;
            `JMP_BE:    w_cond = r_cf || r_zf;
            `JMP_G:     w_cond = !r_zf && (r_sf == r_of);
            `JMP_GE:    w_cond = (r_sf == r_of);
            `JMP_L:     w_cond = (r_sf != r_of);
            `JMP_LE:    w_cond = r_zf || (r_sf != r_of);
            `JMP_S:     w_cond = r_sf;
            `JMP_NS:    w_cond = !r_sf;
            `JMP_O:     w_cond = r_of;
            `JMP_NO:    w_cond = !r_of;
            `JMP_CRZ:   w_cond = (r_cr == 16'd0);
            default:    w_type_ok = 1'b0;
        endcase
    end

    // RET always redirects; LOOP ignores the condition code and branches on the decremented count.
    always_comb begin
        case (r_op)
            OP_RET:  w_con = 1'b1;
            OP_LOOP: w_con = (w_cr_dec != 16'd0);
            default: w_con = w_cond;
        endcase
        w_eval_fault = (((r_op == OP_JMP) || (r_op == OP_CALL)) && !w_type_ok)
                    || ((r_op == OP_CALL) && w_con && (r_sp == SP_FULL))
                    || ((r_op == OP_RET) && (r_sp == '0));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_EVAL;
            S_EVAL:   w_next = w_eval_fault ? S_HALT : S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_HALT;
        endcase
    end

    always_comb begin
        br_if.br_ready = (r_state == S_IDLE) && !r_fault;
        o_flush        = (r_state == S_COMMIT) && r_con;
        w_cr_we        = (r_state == S_COMMIT) && (r_op == OP_LOOP);
        br_if.cr_we    = w_cr_we;
        br_if.cr_o     = w_cr_we ? w_cr_dec : 16'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc     <= RESET_PC;
            r_sp     <= '0;
            r_fault  <= 1'b0;
            r_con    <= 1'b0;
            r_op     <= OP_JMP;
            r_type   <= 4'd0;
            r_target <= 16'd0;
            r_cr     <= 16'd0;
            r_zf     <= 1'b0;
            r_cf     <= 1'b0;
            r_sf     <= 1'b0;
            r_of     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= br_if.br_op;
                        r_type   <= br_if.br_type;
                        r_target <= br_if.br_target;
                        r_cr     <= br_if.cr_i;
                        r_zf     <= br_if.flag[`ALUF_ZF];
                        r_cf     <= br_if.flag[`ALUF_CF];
                        r_sf     <= br_if.flag[`ALUF_SF];
                        r_of     <= br_if.flag[`ALUF_OF];
                    end else if (i_advance) begin
                        r_pc <= w_pc_inc;
                    end
                end
                S_EVAL: begin
                    r_con <= w_con;
                    if (w_eval_fault) r_fault <= 1'b1;
                end
                S_COMMIT: begin
                    case (r_op)
                        OP_RET: begin
                            r_pc <= r_stack[w_sp_dec[AW-1:0]];
                            r_sp <= w_sp_dec;
                        end
                        OP_CALL: begin
                            r_pc <= r_con ? r_target : w_pc_inc;
                            if (r_con) r_sp <= w_sp_inc;
                        end
                        default: r_pc <= r_con ? r_target : w_pc_inc;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Entries are left in place on pop; only the stack pointer moves.
    always_ff @(posedge i_clk) begin
        if (!i_rst && (r_state == S_COMMIT) && (r_op == OP_CALL) && r_con)
            r_stack[r_sp[AW-1:0]] <= w_pc_inc;
    end

    assign o_pc    = r_pc;
    assign o_fault = r_fault;
endmodule
